// File: rtl/dp_ram_pkg.sv
// Shared types and constants for the dp_ram family of memories.
package dp_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dp_ram_state_t;

  localparam int RD_LAT_BASE = 1;

endpackage

// File: rtl/dp_ram_clr_seq.sv
// Clear sequencer: walks a zero-write index over the array after reset or on a
// clear request. busy_o stays high until the last word has been written.
module dp_ram_clr_seq
  import dp_ram_pkg::*;
#(
  parameter int CNT_W = 3,
  parameter int DEPTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  output logic             busy_o,
  output logic             zero_we_o,
  output logic [CNT_W-1:0] zero_addr_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  dp_ram_state_t    state_q;
  logic [CNT_W-1:0] clr_idx_q;
  logic             busy_q;

  // FSM: a clear request at any time restarts the walk from index 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
    end else if (clr_i) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_idx_q == LAST_IDX) begin
            state_q   <= READY;
            clr_idx_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            clr_idx_q <= clr_idx_q + CNT_W'(1);
          end
        end
        READY: begin
          state_q   <= READY;
          clr_idx_q <= '0;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q   <= CLEAR;
          clr_idx_q <= '0;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign zero_we_o   = busy_q;
  assign zero_addr_o = clr_idx_q;

endmodule

// File: rtl/dp_ram.sv
// Simple dual-port RAM with write-first bypass, range checking and hardware clear.
// Define DP_RAM_OUTREG_EN to add a second output register stage (read latency 2).
module dp_ram
  import dp_ram_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DP_RAM_OUTREG_EN
  localparam int OUT_STAGES = RD_LAT_BASE + 1;
`else
  localparam int OUT_STAGES = RD_LAT_BASE;
`endif
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic              busy_s;
  logic              zero_we_s;
  logic [IDX_W-1:0]  zero_addr_s;

  dp_ram_clr_seq #(
    .CNT_W (IDX_W),
    .DEPTH (DEPTH)
  ) u_clr_seq (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .busy_o      (busy_s),
    .zero_we_o   (zero_we_s),
    .zero_addr_o (zero_addr_s)
  );

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_in_s;
  logic              rd_in_s;
  logic              wr_ok_s;
  logic              rd_ok_s;
  logic              mem_we_s;
  logic [IDX_W-1:0]  mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  // Port qualification; clr and busy both drop any access in this cycle
  always_comb begin
    wr_in_s = ({1'b0, wr_addr} < DEPTH_C);
    rd_in_s = ({1'b0, rd_addr} < DEPTH_C);
    wr_ok_s = wr_en & ~busy_s & ~clr & wr_in_s;
    rd_ok_s = rd_en & ~busy_s & ~clr;
    if (zero_we_s) begin
      mem_we_s    = 1'b1;
      mem_addr_s  = zero_addr_s;
      mem_wdata_s = '0;
    end else begin
      mem_we_s    = wr_ok_s;
      mem_addr_s  = wr_addr[IDX_W-1:0];
      mem_wdata_s = wr_data;
    end
  end

  // Storage array, no reset: contents are defined by the clear sequence
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_addr_s] <= mem_wdata_s;
    end
  end

  logic              s1_vld_d, s1_vld_q;
  logic              s1_err_d, s1_err_q;
  logic [DATA_W-1:0] s1_data_d, s1_data_q;

  // Read capture with write-first bypass on a same-address write
  always_comb begin
    s1_vld_d = rd_ok_s;
    s1_err_d = rd_ok_s & ~rd_in_s;
    if (rd_ok_s && rd_in_s) begin
      if (wr_ok_s && (wr_addr == rd_addr)) begin
        s1_data_d = wr_data;
      end else begin
        s1_data_d = mem_q[rd_addr[IDX_W-1:0]];
      end
    end else begin
      s1_data_d = '0;
    end
  end

  // Request stage: a clear request kills the in-flight read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_err_q  <= 1'b0;
      s1_data_q <= '0;
    end else if (clr) begin
      s1_vld_q  <= 1'b0;
      s1_err_q  <= 1'b0;
      s1_data_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_err_q  <= s1_err_d;
      s1_data_q <= s1_data_d;
    end
  end

  logic [DATA_W-1:0]     out_data_q [OUT_STAGES];
  logic [OUT_STAGES-1:0] out_vld_q;
  logic [OUT_STAGES-1:0] out_err_q;

  // Output stage(s): data only advances on a read so it holds between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q <= '0;
      out_err_q <= '0;
      for (int k = 0; k < OUT_STAGES; k++) begin
        out_data_q[k] <= '0;
      end
    end else if (clr) begin
      out_vld_q <= '0;
      out_err_q <= '0;
      for (int k = 0; k < OUT_STAGES; k++) begin
        out_data_q[k] <= '0;
      end
    end else begin
      out_vld_q[0] <= s1_vld_q;
      out_err_q[0] <= s1_err_q;
      if (s1_vld_q) begin
        out_data_q[0] <= s1_data_q;
      end
      for (int k = 1; k < OUT_STAGES; k++) begin
        out_vld_q[k]  <= out_vld_q[k-1];
        out_err_q[k]  <= out_err_q[k-1];
        out_data_q[k] <= out_data_q[k-1];
      end
    end
  end

  assign busy     = busy_s;
  assign rd_data  = out_data_q[OUT_STAGES-1];
  assign rd_valid = out_vld_q[OUT_STAGES-1];
  assign rd_err   = out_err_q[OUT_STAGES-1];

endmodule

// File: tb/tb_dp_ram.sv
// Scoreboard bench for dp_ram (DATA_W=7, ADDR_W=3, DEPTH=6); honours DP_RAM_OUTREG_EN.
module tb_dp_ram;

  localparam int DW    = 7;
  localparam int AW    = 3;
  localparam int DEPTH = 6;
`ifdef DP_RAM_OUTREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic          clk;
  logic          rst;
  logic          clr;
  logic          busy;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_err;

  dp_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_err   (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  logic [DW-1:0] model [DEPTH];
  int            checks   = 0;
  int            failures = 0;

  // Scoreboard monitor: each expected read must appear exactly on its due cycle
  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (mon_e.due != cyc || rd_valid !== 1'b1 || rd_data !== mon_e.data || rd_err !== mon_e.err) begin
        failures++;
        $display("FAIL read_result: cyc=%0d due=%0d got valid=%b data=%0d err=%b, want valid=1 data=%0d err=%b",
                 cyc, mon_e.due, rd_valid, rd_data, rd_err, mon_e.data, mon_e.err);
      end
    end else begin
      checks++;
      if (rd_valid !== 1'b0 || rd_err !== 1'b0) begin
        failures++;
        $display("FAIL idle_strobes: cyc=%0d got valid=%b err=%b, want 0 0", cyc, rd_valid, rd_err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_idle();
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
  endtask

  // One cycle of port traffic; the model is write-first, matching the bypass rule
  task automatic access(input logic we, input int wa, input int wd, input logic re, input int ra);
    logic [DW-1:0] ed;
    wr_en = we; wr_addr = AW'(wa); wr_data = DW'(wd);
    rd_en = re; rd_addr = AW'(ra);
    if (we && wa < DEPTH) model[wa] = DW'(wd);
    if (re) begin
      ed = (ra < DEPTH) ? model[ra] : '0;
      sb_q.push_back('{cyc + 1 + RD_LAT, ed, (ra >= DEPTH)});
    end
    @(negedge clk);
    set_idle();
  endtask

  task automatic drain();
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    set_idle();
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rd_data !== '0 || rd_valid !== 1'b0 || rd_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: busy=%b data=%0d valid=%b err=%b, want 1 0 0 0", busy, rd_data, rd_valid, rd_err);
    end
    rst = 1'b0;
    wait_ready(n);
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL reset_busy_len: got %0d cycles, want %0d", n, DEPTH);
    end
    zero_model();
    for (int a = 0; a < DEPTH; a++) access(1'b0, 0, 0, 1'b1, a);
    drain();
  endtask

  task automatic test_write_read();
    access(1'b1, 0, 1, 1'b0, 0);
    access(1'b1, 1, 2, 1'b0, 0);
    access(1'b1, 5, 3, 1'b0, 0);
    access(1'b0, 0, 0, 1'b1, 0);
    access(1'b0, 0, 0, 1'b1, 1);
    access(1'b0, 0, 0, 1'b1, 5);
    drain();
    // a write alone must leave the held read data untouched
    access(1'b1, 5, 9, 1'b0, 0);
    access(1'b1, 0, 8, 1'b0, 0);
    drain();
    checks++;
    if (rd_data !== 7'd3) begin
      failures++;
      $display("FAIL write_hold: rd_data=%0d, want 3", rd_data);
    end
    access(1'b0, 0, 0, 1'b1, 5);
    drain();
  endtask

  task automatic test_bypass();
    access(1'b1, 2, 4, 1'b1, 2);
    access(1'b0, 0, 0, 1'b0, 0);
    access(1'b0, 0, 0, 1'b1, 2);
    access(1'b1, 3, 50, 1'b1, 3);
    drain();
  endtask

  task automatic test_out_of_range();
    access(1'b1, 6, 39, 1'b0, 0);
    access(1'b1, 7, 41, 1'b0, 0);
    access(1'b0, 0, 0, 1'b1, 6);
    access(1'b1, 6, 12, 1'b1, 6);
    access(1'b0, 0, 0, 1'b1, 7);
    for (int a = 0; a < DEPTH; a++) access(1'b0, 0, 0, 1'b1, a);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 14; i++) begin
      access(1'b1, i % DEPTH, (i * 5 + 1) % 128, 1'b1, (i % 4 == 3) ? 7 : (i + 2) % DEPTH);
    end
    drain();
  endtask

  task automatic test_clear();
    int n;
    for (int a = 0; a < DEPTH; a++) access(1'b1, a, 10 + a, 1'b0, 0);
    access(1'b0, 0, 0, 1'b1, 3);
    drain();
    // clr wins over simultaneous accesses, which are dropped
    clr = 1'b1; rd_en = 1'b1; rd_addr = 3'd3; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 7'd55;
    @(negedge clk);
    set_idle();
    checks++;
    if (rd_data !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL clear_entry: rd_data=%0d busy=%b, want 0 1", rd_data, busy);
    end
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      rd_en = 1'b1; rd_addr = AW'(n % DEPTH);
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 7'd77;
      @(negedge clk);
    end
    set_idle();
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL clear_busy_len: got %0d cycles, want %0d", n, DEPTH);
    end
    zero_model();
    for (int a = 0; a < DEPTH; a++) access(1'b0, 0, 0, 1'b1, a);
    drain();
  endtask

  task automatic test_reset_mid();
    int n;
    access(1'b1, 4, 21, 1'b0, 0);
    access(1'b0, 0, 0, 1'b1, 4);
    drain();
    checks++;
    if (rd_data !== 7'd21) begin
      failures++;
      $display("FAIL pre_reset_data: rd_data=%0d, want 21", rd_data);
    end
    // read accepted but reset before its result is due: never reported
    rd_en = 1'b1; rd_addr = 3'd4;
    @(negedge clk);
    set_idle();
    rst = 1'b1;
    #1;
    checks++;
    if (rd_data !== '0 || rd_valid !== 1'b0 || rd_err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_read: data=%0d valid=%b err=%b busy=%b, want 0 0 0 1", rd_data, rd_valid, rd_err, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL reset_mid_read_busy: got %0d cycles, want %0d", n, DEPTH);
    end
    access(1'b1, 1, 17, 1'b0, 0);
    clr = 1'b1;
    @(negedge clk);
    set_idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || rd_data !== '0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_clear: busy=%b data=%0d valid=%b, want 1 0 0", busy, rd_data, rd_valid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL reset_mid_clear_busy: got %0d cycles, want %0d", n, DEPTH);
    end
    zero_model();
    for (int a = 0; a < DEPTH; a++) access(1'b0, 0, 0, 1'b1, a);
    drain();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    zero_model();
    test_reset();
    test_write_read();
    test_bypass();
    test_out_of_range();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    repeat (4) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: %0d results never arrived, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dp_ram.md
# dp_ram

Parametrised simple dual-port synchronous RAM: one write port, one read port, independent addresses, one clock. Successor to the team's fixed-size dual-port memory. Adds:
- separate depth and address-width parameters;
- defined read-during-write behaviour;
- a read-valid strobe and out-of-range protection;
- a hardware clear sequencer that zeroes the array after reset or on request.

It sits between datapath producers and consumers as a small scratch or lookup store.

## Interface
- DATA_W, 10, word width in bits (≥1)
- ADDR_W, 6, address width in bits (≥1)
- DEPTH, 6, number of words; 1 ≤ DEPTH ≤ 2**ADDR_W
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  single-cycle request to re-zero the whole array
- busy  out  1  clear sequence in progress; ports ignored while high
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read data, held between reads
- rd_valid  out  1  one-cycle pulse: rd_data carries a new read result
- rd_err  out  1  one-cycle pulse: last accepted read was out of range (rd_addr ≥ DEPTH)

## Operation
- State machine, two states:
  - CLEAR: counter clr_idx writes zero to mem[clr_idx], one word per cycle, from 0 to DEPTH-1. Leaves after writing DEPTH-1.
  - READY: normal operation.
- rst asserted: state=CLEAR, clr_idx=0, busy=1, rd_data=0, rd_valid=0, rd_err=0, pipeline cleared. Array contents are undefined until the clear completes.
- clr=1 in READY → CLEAR, clr_idx=0. clr=1 in CLEAR → clr_idx restarts at 0.
- While busy, wr_en and rd_en are dropped (not queued). rd_valid and rd_err stay 0.
- Write is accepted when READY and wr_en. It updates mem[wr_addr] if wr_addr < DEPTH; otherwise it is silently discarded.
- Read is accepted when READY and rd_en:
  - rd_addr < DEPTH: rd_data = mem[rd_addr], rd_err=0.
  - rd_addr ≥ DEPTH: rd_data = 0, rd_err=1.
- Read and write to the same valid address in the same cycle: write-first, rd_data = wr_data.
- Write alone no longer disturbs rd_data (previous generation did). rd_data changes only on an accepted read, reset, or entry to CLEAR (cleared to 0).

## Timing
- Read latency 1: request accepted at edge N → rd_data, rd_valid, rd_err valid after edge N+1 (2 with DP_RAM_OUTREG_EN).
- One read and one write can be accepted every cycle; no back-pressure except busy.
- Clear duration: busy high for exactly DEPTH cycles after rst release (or after the clr edge). The first port access is accepted on the edge after busy falls.
- Reset mid-clear or mid-read: in-flight read is discarded (no rd_valid) and the clear restarts from 0.
- Simultaneous clr and rd_en/wr_en in READY: clr wins and the accesses are dropped.

## Configuration
- DP_RAM_OUTREG_EN defined: extra output register stage on rd_data/rd_valid/rd_err. Read latency is 2; bypass, rd_err and reset rules are unchanged, only delayed one cycle. Reset clears both stages.
- Undefined: latency 1, no extra stage.

## Structure
- Package dp_ram_pkg holds:
  - typedef dp_ram_state_t {CLEAR, READY};
  - localparam RD_LAT_BASE = 1.
- Sub-module dp_ram_clr_seq: state register, clr_idx counter, busy, zero-write strobe/address. It is reused by other memories in the codebase.
- Top level holds the array, port muxing (clear writes override the write port), the bypass compare, and the output stage(s).

## Test plan
All scenarios use DATA_W=7, ADDR_W=3, DEPTH=6.
- Reset release → busy high exactly 6 cycles. Then read each of addresses 0–5 → rd_data=0, rd_valid pulses, rd_err=0.
- Write 7'd1@0, 7'd2@1, 7'd3@5 → read 0, 1, 5 → 1, 2, 3, each valid 1 cycle after request (2 with macro).
- Same cycle wr_addr=2, wr_data=7'd4, rd_addr=2 → rd_data=4 next cycle (bypass). Read 2 again later → 4.
- Write 7'd39@6 (out of range), then read 6 → rd_data=0, rd_err=1. Addresses 0–5 are unchanged.
- Fill addresses 0–5 with non-zero values, pulse clr, issue a read during busy → no rd_valid. After 6 cycles every address reads 0.
- Assert rst 2 cycles into a clear → outputs 0 at once. After release, busy lasts a full 6 cycles.
